// File: rtl/gpr_file_pkg.sv
// Shared constants for the register file and the write-back stage:
// default widths, the hard-wired zero register and the opcode encodings.
package gpr_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_ADDI  = 6'b001000,
        OP_ANDI  = 6'b001100
    } opcode_e;

    // Stores are the only listed opcode that produces no register result.
    function automatic logic writes_rf(input opcode_e op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI) || (op == OP_ANDI);
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by write-back, with a registered count of outstanding writes.
module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic              a_busy,
    output logic              b_busy,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;

    always_comb begin
        busy_d = busy_q;
        if (wb_write && (wb_addr != ADDR_W'(REG_ZERO))) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Applied after the clear so a new producer on the same edge keeps the bit set.
        if (iss_en && (iss_addr != ADDR_W'(REG_ZERO))) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;

        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign a_busy   = busy_q[ra_addr] & ~(BYPASS & wb_write & (wb_addr == ra_addr));
    assign b_busy   = busy_q[rb_addr] & ~(BYPASS & wb_write & (wb_addr == rb_addr));
    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/gpr_file.sv
// 32x32 general-purpose register file with two registered operand ports,
// same-cycle write-back bypass and a pending-write scoreboard for decode.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] WB_Data,
    input  logic              WB_Write,
    input  logic [ADDR_W-1:0] WB_Addr,
    input  logic              Rd_En,
    input  logic [ADDR_W-1:0] RA_Addr,
    input  logic [ADDR_W-1:0] RB_Addr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Rd_Valid,
    input  logic              Iss_En,
    input  logic [ADDR_W-1:0] Iss_Addr,
    output logic              A_Busy,
    output logic              B_Busy,
    output logic [ADDR_W:0]   Pend_Cnt,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              rd_valid_q, rd_valid_d;

    function automatic logic [DATA_W-1:0] rf_read(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              wb_write,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        if (idx == ADDR_W'(REG_ZERO)) return '0;
        if (BYPASS && wb_write && (wb_addr == idx)) return wb_data;
        return stored;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (WB_Write && (WB_Addr != ADDR_W'(REG_ZERO))) begin
            mem_d[WB_Addr] = WB_Data;
        end
    end

    // Rd_En/Rd_Valid: operands are sampled on an edge with Rd_En high and are
    // flagged by Rd_Valid for exactly the following cycle; there is no back-pressure.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        rd_valid_d = Rd_En;
        if (Rd_En) begin
            a_d = rf_read(RA_Addr, mem_q[RA_Addr], WB_Write, WB_Addr, WB_Data);
            b_d = rf_read(RB_Addr, mem_q[RB_Addr], WB_Write, WB_Addr, WB_Data);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            a_q        <= '0;
            b_q        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    gpr_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (Iss_En),
        .iss_addr (Iss_Addr),
        .wb_write (WB_Write),
        .wb_addr  (WB_Addr),
        .ra_addr  (RA_Addr),
        .rb_addr  (RB_Addr),
        .a_busy   (A_Busy),
        .b_busy   (B_Busy),
        .pend_cnt (Pend_Cnt)
    );

    assign A        = a_q;
    assign B        = b_q;
    assign Rd_Valid = rd_valid_q;
    // Register 0 is never written, so the raw array already reads zero there.
    assign Dbg_Data = mem_q[Dbg_Addr];

endmodule
